// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_pkg
//  Description : Shared definitions for the MEM/WB writeback stage: load type
//                encodings, byte-enable constants and a big-endian byte pick.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

  // Load type encodings as presented on in_load_type
  typedef enum logic [2:0] {
    LT_LW   = 3'd0,
    LT_LB   = 3'd1,
    LT_LBU  = 3'd2,
    LT_LH   = 3'd3,
    LT_LHU  = 3'd4,
    LT_LWL  = 3'd5,
    LT_LWR  = 3'd6,
    LT_RSVD = 3'd7
  } load_type_e;

  localparam int unsigned WORD_W = 32;

  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // Byte at offset k of a big-endian word: offset 0 is the most significant byte
  function automatic logic [7:0] be_byte(input logic [WORD_W-1:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage : wb_stage_pkg
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : wb_load_align
//  Description : Combinational load formatter. Maps load type, low address
//                bits and the aligned memory word to register data, per-byte
//                write enables and a misalignment flag (big-endian).
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]        i_load_type,
  input  logic [1:0]        i_addr_lo,
  input  logic [WORD_W-1:0] i_mem_rdata,
  output logic [WORD_W-1:0] o_data,
  output logic [3:0]        o_byte_en,
  output logic              o_misaligned
);

  load_type_e w_lt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_lt   = load_type_e'(i_load_type);
  assign w_byte = be_byte(i_mem_rdata, i_addr_lo);
  assign w_half = i_addr_lo[1] ? i_mem_rdata[15:0] : i_mem_rdata[31:16];

  // Select data, byte enables and alignment fault for each load flavour
  always_comb begin
    o_data       = i_mem_rdata;
    o_byte_en    = BE_ALL;
    o_misaligned = 1'b0;
    case (w_lt)
      LT_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      LT_LBU: o_data = {24'h0, w_byte};
      LT_LH: begin
        o_data       = {{16{w_half[15]}}, w_half};
        o_misaligned = i_addr_lo[0];
      end
      LT_LHU: begin
        o_data       = {16'h0, w_half};
        o_misaligned = i_addr_lo[0];
      end
      // LWL fills the register from the top; unreached low bytes are kept
      LT_LWL: begin
        case (i_addr_lo)
          2'd0: begin o_data = i_mem_rdata;       o_byte_en = 4'b1111; end
          2'd1: begin o_data = i_mem_rdata << 8;  o_byte_en = 4'b1110; end
          2'd2: begin o_data = i_mem_rdata << 16; o_byte_en = 4'b1100; end
          default: begin o_data = i_mem_rdata << 24; o_byte_en = 4'b1000; end
        endcase
      end
      // LWR fills the register from the bottom; unreached high bytes are kept
      LT_LWR: begin
        case (i_addr_lo)
          2'd3: begin o_data = i_mem_rdata;       o_byte_en = 4'b1111; end
          2'd2: begin o_data = i_mem_rdata >> 8;  o_byte_en = 4'b0111; end
          2'd1: begin o_data = i_mem_rdata >> 16; o_byte_en = 4'b0011; end
          default: begin o_data = i_mem_rdata >> 24; o_byte_en = 4'b0001; end
        endcase
      end
      // LW and the reserved encoding share word-load behaviour
      default: o_misaligned = (i_addr_lo != 2'b00);
    endcase
    if (o_misaligned) o_byte_en = BE_NONE;
  end

endmodule : wb_load_align
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : MEM/WB pipeline register and writeback formatter. Drives the
//                register file write port and answers EX forwarding queries
//                against the instruction currently in writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_load_type,
  input  logic [1:0]        in_addr_lo,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  input  logic [ADDR_W-1:0] q_rs_addr,
  input  logic [ADDR_W-1:0] q_rt_addr,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_in,
  output logic [3:0]        Rd_byte_w_en,
  output logic              addr_err,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_partial
);

  logic [DATA_W-1:0] w_ld_data;
  logic [3:0]        w_ld_be;
  logic              w_ld_mis;
  logic              w_misaligned;
  logic              w_write;
  logic [DATA_W-1:0] w_data;
  logic [3:0]        w_be;

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_in;
  logic [3:0]        r_be;
  logic              r_addr_err;

  wb_load_align u_align (
    .i_load_type  (in_load_type),
    .i_addr_lo    (in_addr_lo),
    .i_mem_rdata  (in_mem_rdata),
    .o_data       (w_ld_data),
    .o_byte_en    (w_ld_be),
    .o_misaligned (w_ld_mis)
  );

  // Only a real load can raise an alignment fault
  assign w_misaligned = in_valid & in_mem_to_reg & w_ld_mis;
  assign w_write      = in_valid & in_reg_write & (in_rd_addr != '0) & ~w_misaligned;
  assign w_data       = in_mem_to_reg ? w_ld_data : in_alu_result;
  assign w_be         = in_mem_to_reg ? w_ld_be : BE_ALL;

  // Pipeline register: reset/flush load a bubble, stall holds, else capture MEM
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_reg_write <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_in     <= '0;
      r_be        <= BE_NONE;
      r_addr_err  <= 1'b0;
    end else if (!stall) begin
      r_reg_write <= w_write;
      r_rd_addr   <= in_valid ? in_rd_addr : '0;
      r_rd_in     <= in_valid ? w_data : '0;
      r_be        <= w_write ? w_be : BE_NONE;
      r_addr_err  <= w_misaligned;
    end
  end

  assign RegWrite     = r_reg_write;
  assign rd_addr      = r_rd_addr;
  assign rd_in        = r_rd_in;
  assign Rd_byte_w_en = r_be;
  assign addr_err     = r_addr_err;
  assign fwd_data     = r_rd_in;

  logic w_rs_match;
  logic w_rt_match;
  logic w_full;

  // Forwarding lookup against the writeback in flight; register 0 never matches
  always_comb begin
    w_rs_match  = r_reg_write & (q_rs_addr != '0) & (q_rs_addr == r_rd_addr);
    w_rt_match  = r_reg_write & (q_rt_addr != '0) & (q_rt_addr == r_rd_addr);
    w_full      = (r_be == BE_ALL);
    fwd_rs_hit  = w_rs_match & w_full;
    fwd_rt_hit  = w_rt_match & w_full;
    fwd_partial = (w_rs_match | w_rt_match) & ~w_full;
  end

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Directed self-checking bench for wb_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        in_valid, in_reg_write, in_mem_to_reg;
  logic [2:0]  in_load_type;
  logic [1:0]  in_addr_lo;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_alu_result, in_mem_rdata;
  logic [4:0]  q_rs_addr, q_rt_addr;
  logic        RegWrite, addr_err, fwd_rs_hit, fwd_rt_hit, fwd_partial;
  logic [4:0]  rd_addr;
  logic [31:0] rd_in, fwd_data;
  logic [3:0]  Rd_byte_w_en;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_load_type(in_load_type), .in_addr_lo(in_addr_lo), .in_rd_addr(in_rd_addr),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .q_rs_addr(q_rs_addr), .q_rt_addr(q_rt_addr),
    .RegWrite(RegWrite), .rd_addr(rd_addr), .rd_in(rd_in), .Rd_byte_w_en(Rd_byte_w_en),
    .addr_err(addr_err), .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
    .fwd_data(fwd_data), .fwd_partial(fwd_partial)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [1:0] alo, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mem);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_load_type = lt;
    in_addr_lo = alo; in_rd_addr = rd; in_alu_result = alu; in_mem_rdata = mem;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; q_rs_addr = 5'd4; q_rt_addr = 5'd0;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd4, 32'hCAFE_F00D, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite cyc%0d: got %b want 0", i, RegWrite); end
      checks++; if (Rd_byte_w_en !== 4'b0000) begin errors++; $display("FAIL reset_en cyc%0d: got %b want 0000", i, Rd_byte_w_en); end
      checks++; if (rd_in !== 32'h0) begin errors++; $display("FAIL reset_rd_in cyc%0d: got %h want 0", i, rd_in); end
      checks++; if (fwd_rs_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd cyc%0d: got %b want 0", i, fwd_rs_hit); end
    end
    rst = 1'b0;
  endtask

  task automatic test_byte_loads();
    drive(1'b1, 1'b1, 1'b1, 3'd1, 2'b01, 5'd5, 32'h0, 32'h1280_3456);
    step();
    checks++; if (rd_in !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", rd_in); end
    checks++; if (Rd_byte_w_en !== 4'b1111) begin errors++; $display("FAIL lb_en: got %b want 1111", Rd_byte_w_en); end
    checks++; if (RegWrite !== 1'b1 || rd_addr !== 5'd5) begin errors++; $display("FAIL lb_write: got we=%b rd=%0d want we=1 rd=5", RegWrite, rd_addr); end
    in_load_type = 3'd2;
    step();
    checks++; if (rd_in !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h want 00000080", rd_in); end
    in_load_type = 3'd1; in_addr_lo = 2'b11;
    step();
    checks++; if (rd_in !== 32'h0000_0056) begin errors++; $display("FAIL lb_b3: got %h want 00000056", rd_in); end
  endtask

  task automatic test_halfword();
    drive(1'b1, 1'b1, 1'b1, 3'd3, 2'b00, 5'd6, 32'h0, 32'h8001_3456);
    step();
    checks++; if (rd_in !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_hi: got %h want ffff8001", rd_in); end
    in_load_type = 3'd4;
    step();
    checks++; if (rd_in !== 32'h0000_8001) begin errors++; $display("FAIL lhu_hi: got %h want 00008001", rd_in); end
    in_load_type = 3'd3; in_addr_lo = 2'b10;
    step();
    checks++; if (rd_in !== 32'h0000_3456 || RegWrite !== 1'b1) begin errors++; $display("FAIL lh_lo: got %h we=%b want 00003456 we=1", rd_in, RegWrite); end
  endtask

  task automatic test_lwl_lwr();
    q_rs_addr = 5'd9; q_rt_addr = 5'd0;
    drive(1'b1, 1'b1, 1'b1, 3'd5, 2'b10, 5'd9, 32'h0, 32'hAABB_CCDD);
    step();
    checks++; if (rd_in !== 32'hCCDD_0000) begin errors++; $display("FAIL lwl_data: got %h want ccdd0000", rd_in); end
    checks++; if (Rd_byte_w_en !== 4'b1100) begin errors++; $display("FAIL lwl_en: got %b want 1100", Rd_byte_w_en); end
    checks++; if (fwd_partial !== 1'b1 || fwd_rs_hit !== 1'b0) begin errors++; $display("FAIL lwl_fwd: got partial=%b hit=%b want partial=1 hit=0", fwd_partial, fwd_rs_hit); end
    in_load_type = 3'd6; in_addr_lo = 2'b01;
    step();
    checks++; if (rd_in !== 32'h0000_AABB || Rd_byte_w_en !== 4'b0011) begin errors++; $display("FAIL lwr_1: got %h en=%b want 0000aabb en=0011", rd_in, Rd_byte_w_en); end
    in_addr_lo = 2'b11;
    step();
    checks++; if (Rd_byte_w_en !== 4'b1111 || fwd_rs_hit !== 1'b1 || fwd_partial !== 1'b0) begin errors++; $display("FAIL lwr_3: got en=%b hit=%b partial=%b want 1111 1 0", Rd_byte_w_en, fwd_rs_hit, fwd_partial); end
    q_rs_addr = 5'd0;
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b1, 1'b1, 3'd3, 2'b01, 5'd6, 32'h0, 32'h1234_5678);
    step();
    checks++; if (RegWrite !== 1'b0 || Rd_byte_w_en !== 4'b0000) begin errors++; $display("FAIL mis_lh_write: got we=%b en=%b want 0 0000", RegWrite, Rd_byte_w_en); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_lh_err: got %b want 1", addr_err); end
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'b01, 5'd3, 32'h0000_1234, 32'h0);
    step();
    checks++; if (RegWrite !== 1'b1 || addr_err !== 1'b0 || rd_in !== 32'h0000_1234) begin errors++; $display("FAIL mis_next: got we=%b err=%b data=%h want 1 0 00001234", RegWrite, addr_err, rd_in); end
    drive(1'b1, 1'b1, 1'b1, 3'd0, 2'b10, 5'd8, 32'h0, 32'h1234_5678);
    step();
    checks++; if (addr_err !== 1'b1 || RegWrite !== 1'b0) begin errors++; $display("FAIL mis_lw: got err=%b we=%b want 1 0", addr_err, RegWrite); end
    stall = 1'b1;
    step();
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_stall_hold: got %b want 1", addr_err); end
    stall = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", addr_err); end
  endtask

  task automatic test_alu_fwd();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 32'h5555_5555, 32'h0);
    q_rs_addr = 5'd0; q_rt_addr = 5'd0;
    step();
    checks++; if (RegWrite !== 1'b0 || fwd_rs_hit !== 1'b0) begin errors++; $display("FAIL alu_r0: got we=%b hit=%b want 0 0", RegWrite, fwd_rs_hit); end
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd7, 32'hDEAD_BEEF, 32'h0);
    q_rt_addr = 5'd7;
    step();
    checks++; if (fwd_rt_hit !== 1'b1 || fwd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_fwd_rt: got hit=%b data=%h want 1 deadbeef", fwd_rt_hit, fwd_data); end
    checks++; if (fwd_rs_hit !== 1'b0 || fwd_partial !== 1'b0) begin errors++; $display("FAIL alu_fwd_rs: got hit=%b partial=%b want 0 0", fwd_rs_hit, fwd_partial); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd8, 32'h1111_1111, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (RegWrite !== 1'b1 || rd_addr !== 5'd7 || rd_in !== 32'hDEAD_BEEF || Rd_byte_w_en !== 4'b1111) begin
        errors++; $display("FAIL stall_hold cyc%0d: got we=%b rd=%0d data=%h en=%b want 1 7 deadbeef 1111", i, RegWrite, rd_addr, rd_in, Rd_byte_w_en);
      end
    end
    flush = 1'b1;
    step();
    checks++; if (RegWrite !== 1'b0 || Rd_byte_w_en !== 4'b0000 || rd_in !== 32'h0) begin errors++; $display("FAIL stall_flush: got we=%b en=%b data=%h want 0 0000 0", RegWrite, Rd_byte_w_en, rd_in); end
    flush = 1'b0; stall = 1'b0;
    step();
    checks++; if (RegWrite !== 1'b1 || rd_in !== 32'h1111_1111 || rd_addr !== 5'd8) begin errors++; $display("FAIL post_release: got we=%b rd=%0d data=%h want 1 8 11111111", RegWrite, rd_addr, rd_in); end
  endtask

  initial begin
    test_reset();
    test_byte_loads();
    test_halfword();
    test_lwl_lwr();
    test_misaligned();
    test_alu_fwd();
    test_stall_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_wb_stage
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback formatter. It is the writer side of the register file's write port.
- Latches memory-stage results and formats load data (sub-word extract, sign/zero extend, LWL/LWR merge). Drives rd_addr, rd_in, RegWrite and Rd_byte_w_en into the register file, which samples on negedge.
- Also answers forwarding queries from EX for the in-flight writeback.

Parameters:
- DATA_W, 32, datapath width (fixed at 32 for the byte lane logic)
- ADDR_W, 5, register address width

Ports:
- clk  in  1  clock, posedge
- rst  in  1  synchronous active-high reset
- stall  in  1  hold the pipeline register contents
- flush  in  1  load a bubble into the pipeline register
- in_valid  in  1  MEM stage holds a real instruction
- in_reg_write  in  1  instruction writes a GPR
- in_mem_to_reg  in  1  1 = load result, 0 = ALU result
- in_load_type  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 reserved (treated as LW)
- in_addr_lo  in  2  effective address [1:0]
- in_rd_addr  in  ADDR_W  destination register
- in_alu_result  in  DATA_W  ALU result
- in_mem_rdata  in  DATA_W  aligned memory word
- q_rs_addr, q_rt_addr  in  ADDR_W  EX-stage forwarding queries
- RegWrite  out  1  register file write strobe
- rd_addr  out  ADDR_W  write address
- rd_in  out  DATA_W  write data
- Rd_byte_w_en  out  4  per-byte write enables, bit0 = [7:0]
- addr_err  out  1  misaligned load detected (one pulse per instruction)
- fwd_rs_hit, fwd_rt_hit  out  1  full-word forward available
- fwd_data  out  DATA_W  equals rd_in
- fwd_partial  out  1  query matches a partial-byte write, so EX must stall

Behaviour:
- Reset: all outputs 0. The pipeline register holds a bubble.
- Latency:
  - Formatting is combinational on the MEM inputs.
  - The result is registered on posedge. Outputs are valid one cycle after the inputs.
  - The register file commits on the following negedge, within the same cycle.
- Priority, evaluated per posedge:
  - rst > flush > stall > load.
  - flush with stall: a bubble is loaded.
  - stall: outputs hold, so the identical write is repeated. This is idempotent.
- Bubble: RegWrite=0, Rd_byte_w_en=0, addr_err=0. rd_addr and rd_in are don't-care but are driven to 0.
- RegWrite = in_valid & in_reg_write & (in_rd_addr != 0) & ~misaligned.
  - rd_addr=0 never writes, in every case.
- Non-load (in_mem_to_reg=0): rd_in = alu_result, enables = 1111.
- Byte order is big-endian: the byte at addr_lo=0 is mem_rdata[31:24]. For load formatting, b(k) denotes the byte at offset k.
- LW: rd_in = mem_rdata, enables 1111. Requires addr_lo=00.
- LB / LBU: byte b(addr_lo) is sign- or zero-extended to 32 bits. Enables 1111.
- LH / LHU: halfword at addr_lo[1] (00 → [31:16], 10 → [15:0]) is sign- or zero-extended. Enables 1111. Requires addr_lo[0]=0.
- LWL, by addr_lo:
  - 0: enables 1111, rd_in = mem
  - 1: enables 1110, rd_in = mem<<8
  - 2: enables 1100, rd_in = mem<<16
  - 3: enables 1000, rd_in = mem<<24
- LWR, by addr_lo:
  - 3: enables 1111, rd_in = mem
  - 2: enables 0111, rd_in = mem>>8
  - 1: enables 0011, rd_in = mem>>16
  - 0: enables 0001, rd_in = mem>>24
- Misaligned LW/LH/LHU:
  - Write is suppressed: RegWrite=0, enables 0000.
  - addr_err=1 for exactly the cycle the instruction sits in WB.
  - Under stall, addr_err holds but represents a single event.
- Forwarding (combinational from the registered state):
  - fwd_x_hit = RegWrite & (q_x_addr == rd_addr) & (enables == 1111). Here x is rs or rt.
  - fwd_partial = RegWrite & match on either query & (enables != 1111).
  - Query address 0 never hits.

Decomposition:
- Shared package holds:
  - load type encodings (LT_LW..LT_LWR)
  - byte-enable constants BE_ALL = 4'b1111 and BE_NONE
  - big-endian byte index helper
- One sub-module: wb_load_align. It is purely combinational, maps (load_type, addr_lo, mem_rdata) to (data, byte_en, misaligned), and is reusable by the store path.

Test Plan:
- Reset: rst=1 for 2 cycles with valid inputs driven → RegWrite=0, Rd_byte_w_en=0, rd_in=0 throughout.
- LB, addr_lo=01, mem=0x1280_3456, rd=5 → next cycle rd_in=0xFFFFFF80, en=1111, RegWrite=1. As LBU → rd_in=0x00000080.
- LWL, addr_lo=10, mem=0xAABBCCDD, rd=9 → rd_in=0xCCDD0000, en=1100. Query q_rs_addr=9 → fwd_partial=1, fwd_rs_hit=0.
- LH, addr_lo=01 → RegWrite=0, en=0000, addr_err=1 for one cycle. Next instruction, ALU rd=3 value 0x1234, gives RegWrite=1 and addr_err=0.
- ALU write with rd=0 → RegWrite=0. ALU rd=7 value 0xDEADBEEF with q_rt_addr=7 → fwd_rt_hit=1, fwd_data=0xDEADBEEF.
- stall and flush together with a valid write pending → bubble loaded (RegWrite=0). Stall alone for 3 cycles → outputs identical each cycle.
